// File: rtl/dmem_arb_pkg.sv
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared types and constants for the data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-requester round-robin winner select with last-served pointer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_update,
  output logic o_any,
  output logic o_win
);

  logic r_last;

  // On a tie the port that was not served last takes the slot.
  always_comb begin
    o_any = i_req0 | i_req1;
    if (i_req0 && i_req1) begin
      o_win = ~r_last;
    end else if (i_req1) begin
      o_win = PORT_DBG;
    end else begin
      o_win = PORT_CPU;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last <= PORT_DBG;
    end else if (i_update && o_any) begin
      r_last <= o_win;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-port round-robin arbiter in front of a single-ported dmem.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);

  state_t              r_state;
  state_t              w_next;
  logic                w_accept;
  logic                w_any;
  logic                w_win;
  logic                r_idx;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;

  rr_arbiter2 u_rr (
    .clk      (clk),
    .reset    (reset),
    .i_req0   (req0),
    .i_req1   (req1),
    .i_update (w_accept),
    .o_any    (w_any),
    .o_win    (w_win)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // RESP arbitrates exactly like IDLE so back-to-back traffic needs no idle gap.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      IDLE, RESP: begin
        if (w_any) begin
          w_next   = ACCESS;
          w_accept = 1'b1;
        end else begin
          w_next   = IDLE;
        end
      end
      ACCESS:  w_next = RESP;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx   <= PORT_CPU;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_idx   <= w_win;
      r_we    <= (w_win == PORT_DBG) ? we1 : we0;
      r_addr  <= (w_win == PORT_DBG) ? addr1 : addr0;
      r_wdata <= (w_win == PORT_DBG) ? wdata1 : wdata0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else if (r_state == ACCESS && !r_we) begin
      if (r_idx == PORT_DBG) begin
        r_rdata1 <= mem_read_data;
      end else begin
        r_rdata0 <= mem_read_data;
      end
    end
  end

  assign gnt0           = (r_state == ACCESS) && (r_idx == PORT_CPU);
  assign gnt1           = (r_state == ACCESS) && (r_idx == PORT_DBG);
  assign rvalid0        = (r_state == RESP) && (r_idx == PORT_CPU);
  assign rvalid1        = (r_state == RESP) && (r_idx == PORT_DBG);
  assign rdata0         = r_rdata0;
  assign rdata1         = r_rdata1;
  assign mem_read       = (r_state == ACCESS) && !r_we;
  assign mem_write      = (r_state == ACCESS) && r_we;
  assign mem_address    = r_addr;
  assign mem_write_data = r_wdata;
  assign busy           = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Scoreboard bench for dmem_arbiter with a behavioural data memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] data;
  } req_t;

  typedef struct {
    logic        port;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wd;
    logic [63:0] rd;
    int          gcyc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [63:0] addr0, wdata0, addr1, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [63:0] rdata0, rdata1;
  logic        mem_read, mem_write, busy;
  logic [63:0] mem_address, mem_write_data, mem_read_data;

  logic [63:0] mem [64];
  req_t        pend0[$];
  req_t        pend1[$];
  exp_t        exp_g[$];
  exp_t        exp_r[$];
  int          g1_cyc[$];
  exp_t        mg;
  exp_t        mr;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  dmem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .req0           (req0),
    .we0            (we0),
    .addr0          (addr0),
    .wdata0         (wdata0),
    .req1           (req1),
    .we1            (we1),
    .addr1          (addr1),
    .wdata1         (wdata1),
    .gnt0           (gnt0),
    .gnt1           (gnt1),
    .rvalid0        (rvalid0),
    .rvalid1        (rvalid1),
    .rdata0         (rdata0),
    .rdata1         (rdata1),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mem_read_data = mem[mem_address[8:3]];

  // Write lands mid-cycle while mem_write is high, so an aborted ACCESS never commits.
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 64'h0;
    mem[0] = 64'h1111;
    mem[1] = 64'h2222;
    forever begin
      @(negedge clk);
      if (mem_write) mem[mem_address[8:3]] = mem_write_data;
    end
  end

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_req(input logic p, input logic we, input logic [63:0] a, input logic [63:0] d);
    req_t t;
    t.we = we; t.addr = a; t.data = d;
    if (p) pend1.push_back(t);
    else   pend0.push_back(t);
  endtask

  task automatic push_exp(input logic p, input logic we, input logic [63:0] a,
                          input logic [63:0] wd, input logic [63:0] rd);
    exp_t e;
    e.port = p; e.we = we; e.addr = a; e.wd = wd; e.rd = rd; e.gcyc = 0;
    exp_g.push_back(e);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      done = (pend0.size() == 0) && (pend1.size() == 0) && (exp_g.size() == 0) &&
             (exp_r.size() == 0) && !busy && !req0 && !req1;
    end
    if (!done) chk(1'b0, "idle_timeout", 64'(exp_g.size() + exp_r.size()), 64'h0);
  endtask

  // Requester model: hold req until gnt, drop it in ACCESS, issue the next one in RESP.
  initial begin
    req_t t;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    forever begin
      @(posedge clk);
      #1;
      if (req0 && gnt0) begin
        req0 = 1'b0;
      end else if (!req0 && pend0.size() > 0) begin
        t = pend0.pop_front();
        req0 = 1'b1; we0 = t.we; addr0 = t.addr; wdata0 = t.data;
      end
      if (req1 && gnt1) begin
        req1 = 1'b0;
      end else if (!req1 && pend1.size() > 0) begin
        t = pend1.pop_front();
        req1 = 1'b1; we1 = t.we; addr1 = t.addr; wdata1 = t.data;
      end
    end
  end

  always @(negedge clk) begin
    chk(((gnt0 & gnt1) == 1'b0) && ((rvalid0 & rvalid1) == 1'b0) &&
        ((mem_read | mem_write) == (gnt0 | gnt1)),
        "onehot", {61'h0, gnt0 & gnt1, rvalid0 & rvalid1, mem_read | mem_write},
        {63'h0, gnt0 | gnt1});
    if (gnt0 || gnt1) begin
      if (exp_g.size() == 0) begin
        chk(1'b0, "unexpected_gnt", {62'h0, gnt1, gnt0}, 64'h0);
      end else begin
        mg = exp_g.pop_front();
        chk(gnt1 == mg.port, "gnt_port", {63'h0, gnt1}, {63'h0, mg.port});
        chk(mem_write == mg.we, "mem_write", {63'h0, mem_write}, {63'h0, mg.we});
        chk(mem_read == !mg.we, "mem_read", {63'h0, mem_read}, {63'h0, !mg.we});
        chk(mem_address == mg.addr, "mem_address", mem_address, mg.addr);
        if (mg.we) chk(mem_write_data == mg.wd, "mem_write_data", mem_write_data, mg.wd);
        mg.gcyc = cyc;
        exp_r.push_back(mg);
        if (gnt1) g1_cyc.push_back(cyc);
      end
    end
    if (rvalid0 || rvalid1) begin
      if (exp_r.size() == 0) begin
        chk(1'b0, "unexpected_rvalid", {62'h0, rvalid1, rvalid0}, 64'h0);
      end else begin
        mr = exp_r.pop_front();
        chk(rvalid1 == mr.port, "rvalid_port", {63'h0, rvalid1}, {63'h0, mr.port});
        chk(cyc == mr.gcyc + 1, "rvalid_latency", 64'(cyc - mr.gcyc), 64'h1);
        if (!mr.we) chk((rvalid1 ? rdata1 : rdata0) == mr.rd, "rdata",
                        rvalid1 ? rdata1 : rdata0, mr.rd);
      end
    end
  end

  initial begin
    bit seen;
    reset = 1'b0;
    push_req(1'b0, 1'b1, 64'h10, 64'hDEAD_BEEF);
    push_req(1'b1, 1'b0, 64'h10, 64'h0);
    push_exp(1'b0, 1'b1, 64'h10, 64'hDEAD_BEEF, 64'h0);
    push_exp(1'b1, 1'b0, 64'h10, 64'h0, 64'hDEAD_BEEF);
    repeat (3) begin
      @(negedge clk);
      chk({gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_write, busy} == 7'h0, "reset_ctrl",
          {57'h0, gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_write, busy}, 64'h0);
      chk((mem_address | mem_write_data) == 64'h0, "reset_mem_bus", mem_address | mem_write_data, 64'h0);
      chk((rdata0 | rdata1) == 64'h0, "reset_rdata", rdata0 | rdata1, 64'h0);
    end
    chk(req0 && req1, "reset_reqs_held", {62'h0, req1, req0}, 64'h3);
    reset = 1'b1;
    wait_idle();

    push_req(1'b0, 1'b0, 64'h10, 64'h0);
    push_exp(1'b0, 1'b0, 64'h10, 64'h0, 64'hDEAD_BEEF);
    wait_idle();
    chk(rdata0 == 64'hDEAD_BEEF, "rdata0_after_read", rdata0, 64'hDEAD_BEEF);
    push_req(1'b1, 1'b1, 64'h18, 64'h3333);
    push_exp(1'b1, 1'b1, 64'h18, 64'h3333, 64'h0);
    wait_idle();
    chk(mem[3] == 64'h3333, "mem_18", mem[3], 64'h3333);

    for (int i = 0; i < 4; i++) begin
      push_req(1'b0, 1'b0, 64'h0, 64'h0);
      push_req(1'b1, 1'b0, 64'h8, 64'h0);
      push_exp(1'b0, 1'b0, 64'h0, 64'h0, 64'h1111);
      push_exp(1'b1, 1'b0, 64'h8, 64'h0, 64'h2222);
    end
    wait_idle();

    g1_cyc.delete();
    push_req(1'b1, 1'b1, 64'h28, 64'hAAAA);
    push_req(1'b1, 1'b0, 64'h28, 64'h0);
    push_req(1'b1, 1'b1, 64'h30, 64'hBBBB);
    push_exp(1'b1, 1'b1, 64'h28, 64'hAAAA, 64'h0);
    push_exp(1'b1, 1'b0, 64'h28, 64'h0, 64'hAAAA);
    push_exp(1'b1, 1'b1, 64'h30, 64'hBBBB, 64'h0);
    wait_idle();
    chk(g1_cyc.size() == 3, "b2b_count", 64'(g1_cyc.size()), 64'h3);
    if (g1_cyc.size() == 3) begin
      chk(g1_cyc[1] - g1_cyc[0] == 2, "b2b_spacing0", 64'(g1_cyc[1] - g1_cyc[0]), 64'h2);
      chk(g1_cyc[2] - g1_cyc[1] == 2, "b2b_spacing1", 64'(g1_cyc[2] - g1_cyc[1]), 64'h2);
    end

    repeat (10) begin
      @(negedge clk);
      chk({busy, mem_read, mem_write} == 3'b000, "idle_hold",
          {61'h0, busy, mem_read, mem_write}, 64'h0);
    end
    chk(rdata0 == 64'h1111, "idle_rdata0", rdata0, 64'h1111);
    chk(rdata1 == 64'hAAAA, "idle_rdata1", rdata1, 64'hAAAA);

    push_req(1'b1, 1'b1, 64'h20, 64'h5555);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = gnt1;
    end
    chk(seen, "abort_gnt_seen", {63'h0, seen}, 64'h1);
    #2;
    reset = 1'b0;
    #1;
    chk({mem_write, gnt1, busy} == 3'b000, "abort_async_drop",
        {61'h0, mem_write, gnt1, busy}, 64'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk(busy == 1'b0, "abort_idle", {63'h0, busy}, 64'h0);
    chk(mem[4] == 64'h0, "abort_no_write", mem[4], 64'h0);
    chk(exp_r.size() == 0 && exp_g.size() == 0, "abort_queues",
        64'(exp_r.size() + exp_g.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Sequential two-port arbiter that shares the single-ported data memory (`data_memory`) between the CPU load/store port (port 0) and a debug/program-loader port (port 1). It sits between the requesters and `dmem`, latches one winning transaction at a time, drives the memory control/address/data for exactly one cycle, and returns a completion pulse with read data. Round-robin fairness guarantees neither port starves.

## Interface
Parameters:
- `ADDR_W`, 64, address width; matches `data_memory.address`.
- `DATA_W`, 64, data width; matches `data_memory` read/write data.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. Low forces reset state immediately; release is synchronous to `clk`.
- `req0` / `req1`  in  1  transaction request, port 0 (CPU) / port 1 (debug).
- `we0` / `we1`  in  1  1 = write, 0 = read; valid while the port's `req` is high.
- `addr0` / `addr1`  in  ADDR_W  byte address.
- `wdata0` / `wdata1`  in  DATA_W  write data.
- `gnt0` / `gnt1`  out  1  one-cycle pulse: the port's request was accepted and is being executed.
- `rvalid0` / `rvalid1`  out  1  one-cycle completion pulse, for both reads and writes.
- `rdata0` / `rdata1`  out  DATA_W  read data; valid when `rvalid` is high after a read.
- `mem_read`  out  1  to `data_memory.mem_read`.
- `mem_write`  out  1  to `data_memory.mem_write`.
- `mem_address`  out  ADDR_W  to `data_memory.address`.
- `mem_write_data`  out  DATA_W  to `data_memory.write_data`.
- `mem_read_data`  in  DATA_W  from `data_memory.read_data`; combinational read.
- `busy`  out  1  high in ACCESS or RESP.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if neither `req` is high, stay. Otherwise pick a winner, latch its `we`/`addr`/`wdata` and index, update the round-robin pointer, and go to ACCESS.
- ACCESS (1 cycle):
  - assert the winner's `gnt`;
  - drive `mem_address`/`mem_write_data` from the latched registers;
  - `mem_read` = !we, `mem_write` = we;
  - on the closing edge, a write commits in `data_memory`, and for a read `mem_read_data` is captured into the winner's `rdata` register;
  - go to RESP.
- RESP (1 cycle):
  - pulse the winner's `rvalid`;
  - perform the same arbitration as IDLE: go to ACCESS if any `req` is high, else go to IDLE.
- Arbitration:
  - only one request: it wins;
  - both requesting: the port not served last wins;
  - pointer `last` resets to 1, so port 0 wins the first tie.
- Requester rule: hold `req` and its payload stable until `gnt`. In the cycle after `gnt` (RESP), `req` high means a new transaction.
- `rdata0`/`rdata1` hold their value until the next read response to that port. Write responses do not change them.
- Memory outputs outside ACCESS: `mem_read` = `mem_write` = 0; `mem_address` and `mem_write_data` hold the latched values.
- No request is ever dropped or duplicated. The payload is sampled only at the accepting edge.

## Timing
- Reset values: state IDLE, `last` = 1, and all outputs 0 (`gnt*`, `rvalid*`, `mem_*`, `busy`, `rdata*`, latched address/data).
- Latency: `req` sampled at edge E gives `gnt` in cycle E+1 (ACCESS) and `rvalid` in cycle E+2 (RESP).
- Throughput: 1 transaction per 3 cycles from IDLE, or per 2 cycles when back-to-back (RESP→ACCESS).
- Contention: with both ports requesting continuously, grants alternate 0,1,0,1. The worst-case wait for the losing port is one transaction (2 cycles).
- Reset mid-operation: outputs drop to 0 asynchronously, with no `mem_write` after `reset` falls. An in-flight transaction is abandoned and produces no `rvalid`. A write whose edge coincided with reset assertion is not guaranteed.
- Only one `gnt` and one `rvalid` may be high in any cycle, and never both ports at once.

## Structure
- Shared package `dmem_arb_pkg`:
  - state encoding IDLE=2'd0, ACCESS=2'd1, RESP=2'd2;
  - port index constants PORT_CPU=0, PORT_DBG=1.
- Sub-module `rr_arbiter2`: combinational winner from `req0`, `req1`, `last`, plus a registered `last` pointer with async active-low reset.
- Top level holds the FSM, payload latches, per-port `rdata` registers, and memory drive.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with `req0`=`req1`=1. Required: all outputs 0, no `gnt`; after release, `gnt0` pulses first.
- Single write then read, port 0: write addr 0x10, data 0xDEAD_BEEF → `gnt0` at +1, `mem_write`=1 for exactly one cycle, `rvalid0` at +2. Then read 0x10 → `rdata0`=0xDEAD_BEEF with `rvalid0`.
- Contention: both ports request continuously with reads of 0x0 and 0x8 for 8 transactions. Required: grant order 0,1,0,1,…; each `rdata` matches its memory contents; never two `gnt`s in one cycle.
- Back-to-back: port 1 re-asserts `req` in its RESP cycle. Required: ACCESS immediately follows RESP; transaction spacing is 2 cycles.
- Reset mid-ACCESS: assert `reset` low during a port-1 write of 0x5555 to 0x20. Required: `mem_write` falls immediately, no `rvalid1`, state IDLE after release.
- Idle-hold: no requests for 10 cycles. Required: `busy`=0, `mem_read`=`mem_write`=0, `rdata*` unchanged.
